// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// the address tag that marks peripheral space, and default bus widths.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam int          DMEM_DATA_W     = 32;
    localparam int          DMEM_ADDR_W     = 32;
    localparam logic [3:0]  DMEM_PERIPH_TAG = 4'h4;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req  in  2  request vector, bit i = port i
//   last in  1  port served most recently
//   sel  out 1  chosen port (only meaningful when |req)
module dmem_arbiter_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel
);

    always_comb begin
        sel = 1'b0;
        case (req)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last;   // tie goes to the port not served last
            default: sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 is the CPU, port 1 the debug/boot loader. One access per grant,
// round-robin on ties, fixed req->ack latency of 2 cycles after the grant.
// Peripheral-space addresses (top nibble == PERIPH_TAG) are acked with err
// and never reach the memory enables.
//   clk, reset                          clock, synchronous active-high reset
//   req/wr/addr/wdata 0,1               requester inputs, held until ack
//   ack/rdata/err 0,1                   one-cycle completion, data, error
//   mem_rd/mem_wr/mem_addr/mem_wdata    memory control, driven in ACCESS only
//   mem_rdata                           combinational read data from memory
//   busy                                high whenever not IDLE
//
// state  | meaning
// IDLE   | waiting for a request; grant decided here
// ACCESS | memory pins driven from the selected port, result captured
// DONE   | ack pulse to the selected port, round-robin pointer updated
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int         DATA_W     = DMEM_DATA_W,
    parameter int         ADDR_W     = DMEM_ADDR_W,
    parameter logic [3:0] PERIPH_TAG = DMEM_PERIPH_TAG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t        state, state_nx;
    logic              sel, last, pick;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              wr_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              periph;

    dmem_arbiter_rr_pick2 u_pick (
        .req  ({req1, req0}),
        .last (last),
        .sel  (pick)
    );

    assign wr_sel    = sel ? wr1    : wr0;
    assign addr_sel  = sel ? addr1  : addr0;
    assign wdata_sel = sel ? wdata1 : wdata0;
    assign periph    = (addr_sel[ADDR_W-1 -: 4] == PERIPH_TAG);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            sel     <= 1'b0;
            last    <= 1'b1;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && (req0 || req1))
                sel <= pick;
            if (state == ST_ACCESS) begin
                rdata_q <= (wr_sel || periph) ? '0 : mem_rdata;
                err_q   <= periph;
            end
            if (state == ST_DONE)
                last <= sel;
        end
    end

    always_comb begin
        state_nx  = state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        err0      = 1'b0;
        err1      = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (req0 || req1)
                    state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_addr  = addr_sel;
                mem_wdata = wdata_sel;
                mem_wr    = wr_sel & ~periph;
                mem_rd    = ~wr_sel & ~periph;
                state_nx  = ST_DONE;
            end
            ST_DONE: begin
                if (sel) begin
                    ack1   = 1'b1;
                    rdata1 = rdata_q;
                    err1   = err_q;
                end else begin
                    ack0   = 1'b1;
                    rdata0 = rdata_q;
                    err0   = err_q;
                end
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rq [2];
    logic        rw [2];
    logic [31:0] ra [2];
    logic [31:0] rd [2];
    logic        ack0, ack1, err0, err1, mem_rd, mem_wr, busy;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] env_mem [256] = '{default: 32'h0};
    logic [31:0] ref_mem [256] = '{default: 32'h0};

    txn_t q [2][$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   chk_on = 1'b0;
    bit   gap_on = 1'b0;
    logic ack_seen [2];

    // transaction-level reference: one outstanding grant, timed by arithmetic
    bit          g_valid = 1'b0;
    int          g_cyc = 0;
    logic        g_port = 1'b0;
    logic        g_wr = 1'b0;
    logic [31:0] g_addr = 32'h0;
    logic [31:0] g_wdata = 32'h0;
    logic        m_last = 1'b1;
    logic [31:0] e_rdata = 32'h0;
    logic        e_err = 1'b0;

    always #5 clk = ~clk;

    assign mem_rdata = env_mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_wr) env_mem[mem_addr[9:2]] <= mem_wdata;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(rq[0]), .wr0(rw[0]), .addr0(ra[0]), .wdata0(rd[0]),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(rq[1]), .wr1(rw[1]), .addr1(ra[1]), .wdata1(rd[1]),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        t.wr = wr; t.addr = addr; t.data = data;
        return t;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [3:0] top;
        logic [7:0] idx;
        top = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) top = 4'h4;
        else if (top == 4'h4) top = 4'h5;
        idx = 8'($urandom_range(0, 15));
        return {top, 18'($urandom), idx, 2'($urandom)};
    endfunction

    // requesters: hold until ack, then drop or present the next queued access
    initial begin
        rq[0] = 0; rq[1] = 0; rw[0] = 0; rw[1] = 0;
        ra[0] = 0; ra[1] = 0; rd[0] = 0; rd[1] = 0;
        ack_seen[0] = 0; ack_seen[1] = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int p = 0; p < 2; p++) begin
                if (ack_seen[p]) rq[p] = 1'b0;
                if (!reset && !rq[p] && q[p].size() > 0 &&
                    (!gap_on || $urandom_range(0, 2) == 0)) begin
                    txn_t t;
                    t = q[p].pop_front();
                    rq[p] = 1'b1; rw[p] = t.wr; ra[p] = t.addr; rd[p] = t.data;
                end
            end
        end
    end

    // reference model and per-cycle checks
    initial begin
        forever begin
            bit   in_acc, in_ack, per, ea0, ea1;
            logic p;
            @(negedge clk);
            ack_seen[0] = ack0;
            ack_seen[1] = ack1;
            if (chk_on) begin
                in_acc = g_valid && (cyc == g_cyc + 1);
                in_ack = g_valid && (cyc == g_cyc + 2);
                per    = (g_addr[31:28] == 4'h4);
                if (in_acc) begin
                    e_err   = per;
                    e_rdata = (g_wr || per) ? 32'h0 : ref_mem[g_addr[9:2]];
                    if (g_wr && !per) ref_mem[g_addr[9:2]] = g_wdata;
                end
                ea0 = in_ack && (g_port == 1'b0);
                ea1 = in_ack && (g_port == 1'b1);
                chk("mem_wr",    32'(mem_wr), 32'(in_acc && g_wr && !per));
                chk("mem_rd",    32'(mem_rd), 32'(in_acc && !g_wr && !per));
                chk("mem_addr",  mem_addr,  in_acc ? g_addr  : 32'h0);
                chk("mem_wdata", mem_wdata, in_acc ? g_wdata : 32'h0);
                chk("busy",      32'(busy), 32'(in_acc || in_ack));
                chk("ack0",      32'(ack0), 32'(ea0));
                chk("ack1",      32'(ack1), 32'(ea1));
                chk("rdata0",    rdata0, ea0 ? e_rdata : 32'h0);
                chk("rdata1",    rdata1, ea1 ? e_rdata : 32'h0);
                chk("err0",      32'(err0), 32'(ea0 && e_err));
                chk("err1",      32'(err1), 32'(ea1 && e_err));
                if (reset) begin
                    g_valid = 1'b0;
                    m_last  = 1'b1;
                end else begin
                    if (in_ack) g_valid = 1'b0;
                    if (!in_acc && !in_ack && (rq[0] || rq[1])) begin
                        p = (rq[0] && rq[1]) ? ~m_last : rq[1];
                        g_valid = 1'b1; g_cyc = cyc; g_port = p;
                        g_wr = rw[p]; g_addr = ra[p]; g_wdata = rd[p];
                        m_last = p;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string tag, input int budget);
        int pend;
        pend = 1;
        for (int i = 0; i < budget && pend != 0; i++) begin
            @(posedge clk);
            #3;
            pend = q[0].size() + q[1].size() + int'(rq[0]) + int'(rq[1]) + int'(g_valid);
        end
        if (pend != 0) chk(tag, 32'(pend), 32'h0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #2 chk_on = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;

        // simultaneous requests right after reset: port 0 wins the first tie
        q[0].push_back(mk(1'b0, 32'h0000_0020, 32'h0));
        q[1].push_back(mk(1'b0, 32'h0000_0024, 32'h0));
        wait_idle("t2_idle", 50);

        // write then read back
        q[0].push_back(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF));
        q[0].push_back(mk(1'b0, 32'h0000_0010, 32'h0));
        wait_idle("t1_idle", 50);

        // both ports streaming reads: strict alternation
        for (int i = 0; i < 2; i++) begin
            q[0].push_back(mk(1'b0, 32'h0000_0010, 32'h0));
            q[1].push_back(mk(1'b0, 32'h0000_0010, 32'h0));
        end
        wait_idle("t3_idle", 60);

        // peripheral write is rejected
        q[1].push_back(mk(1'b1, 32'h4000_0000, 32'h1234_5678));
        wait_idle("t4_idle", 50);

        // aliasing through addr[9:2]
        q[0].push_back(mk(1'b1, 32'h0000_03FC, 32'h0000_0005));
        q[0].push_back(mk(1'b0, 32'h0000_07FC, 32'h0));
        wait_idle("t6_idle", 50);

        // reset during DONE of a port-0 read, then port 1 alone
        q[0].push_back(mk(1'b0, 32'h0000_0010, 32'h0));
        n = 0;
        while (n < 50 && !(g_valid && g_port == 1'b0 && cyc == g_cyc + 2)) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 50) chk("t5_wait", 32'(n), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        q[1].push_back(mk(1'b0, 32'h0000_03FC, 32'h0));
        wait_idle("t5_idle", 50);

        // randomized traffic with random gaps
        gap_on = 1'b1;
        for (int i = 0; i < 200; i++) begin
            q[0].push_back(mk(1'($urandom), rand_addr(), $urandom));
            q[1].push_back(mk(1'($urandom), rand_addr(), $urandom));
        end
        wait_idle("rand_idle", 6000);

        repeat (2) @(posedge clk);
        for (int i = 0; i < 256; i++) chk("mem_final", env_mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
